control_unit: RTL
=================

CONTROL_UNIT -- requirements
Module: control_unit

Interface
REQ-001 SHALL have parameter ADDR_W, default 8, instruction-memory address and PC width.
REQ-002 SHALL have port clk  input  1  single clock; all state updates on rising edge.
REQ-003 SHALL have port reset  input  1  asynchronous, active-high reset.
REQ-004 SHALL have port imem_addr  output  ADDR_W  instruction-memory read address.
REQ-005 SHALL have port imem_data  input  8  instruction byte, valid one cycle after imem_addr is presented (synchronous-read memory).
REQ-006 SHALL have port alu_a  output  4  ALU operand A.
REQ-007 SHALL have port alu_b  output  4  ALU operand B.
REQ-008 SHALL have port alu_opcode  output  4  ALU operation code: ADD 0001, SUB 0010, AND 0011, OR 0100, XOR 0101, NOT 0110, SHL 0111, SHR 1000.
REQ-009 SHALL have port alu_result  input  4  combinational ALU result.
REQ-010 SHALL have port alu_zero  input  1  combinational ALU zero flag.
REQ-011 SHALL have port instr_done  output  1  one-cycle pulse when an instruction retires.
REQ-012 SHALL have port halted  output  1  high while in HALT.
REQ-013 SHALL have port dbg_sel  input  2  register-file debug read select.
REQ-014 SHALL have port dbg_data  output  4  combinational read of reg[dbg_sel].

Function
REQ-015 Instruction format SHALL be [7:4] opcode, [3:2] rd, [1:0] rs; four 4-bit registers r0..r3, one zero flag Z, one ADDR_W-bit PC.
REQ-016 Opcodes 0001-1000 SHALL be ALU ops, rd <= rd op rs (NOT/SHL/SHR ignore rs), Z <= alu_zero.
REQ-017 Opcode 1001 LDI SHALL be two bytes: rd <= low nibble of second byte; Z unchanged.
REQ-018 Opcode 1010 JZ SHALL be two bytes: if Z=1 PC <= second byte, else PC <= PC+1 past the operand.
REQ-019 Opcode 0000 NOP and undefined 1011-1110 SHALL retire with no state change other than PC.
REQ-020 Opcode 1111 HALT SHALL enter HALT and stay until reset.
REQ-021 States: FETCH -> DECODE -> {EXEC | FETCH2 | FETCH | HALT}; EXEC -> FETCH; FETCH2 -> OPERAND -> FETCH.
REQ-022 FETCH: imem_addr = PC.
REQ-023 DECODE: IR <= imem_data, PC <= PC+1; branch on opcode.
REQ-024 EXEC: alu_a = reg[rd], alu_b = reg[rs], alu_opcode = IR[7:4]; at edge reg[rd] <= alu_result, Z <= alu_zero.
REQ-025 FETCH2: imem_addr = PC; OPERAND consumes imem_data.
REQ-026 alu_opcode SHALL be 0000 and alu_a/alu_b 0 in every state other than EXEC.
REQ-027 Latency: NOP 2 cycles, ALU op 3 cycles, LDI/JZ 4 cycles, FETCH to next FETCH.
REQ-028 instr_done SHALL pulse in the cycle the instruction's last state is active (DECODE for NOP/undefined/HALT, EXEC, OPERAND).
REQ-029 PC SHALL wrap modulo 2^ADDR_W (all-ones +1 -> 0), including across a two-byte instruction.
REQ-030 Writing rd = rs SHALL use the pre-edge value as both operands.

Reset
REQ-031 Reset SHALL immediately force state FETCH, PC 0, r0..r3 0, Z 0, IR 0, halted 0, instr_done 0, alu_opcode 0000.
REQ-032 Reset asserted mid-instruction SHALL discard it with no register write; fetch restarts at address 0 on the first edge after deassertion.

Verification
REQ-033 Program LDI r0,3; LDI r1,5; ADD r0,r1; HALT -> r0=8, Z=0, halted=1, four instr_done pulses, EXEC shows alu_opcode 0001.
REQ-034 LDI r2,4; SUB r2,r2; JZ 0x10; at 0x10 HALT -> Z=1, PC reaches 0x10, halted=1.
REQ-035 Z=0 then JZ 0x10 -> not taken, next fetch at jump address + 2.
REQ-036 Place NOP at 0xFF, LDI r3,7 at 0x00 -> PC wraps to 0, r3=7.
REQ-037 Assert reset during EXEC of ADD -> target register unchanged (0), PC 0, next imem_addr 0.
REQ-038 Cycle-count check: ALU op retires exactly 3 cycles after its FETCH; LDI exactly 4.

Source files
------------

// File: rtl/control_unit_if.sv
// Instruction-memory and ALU connections of the control unit, bundled so the
// controller (master) and the memory/ALU side (slave) see consistent directions.
interface control_unit_if #(
    parameter int ADDR_W = 8
);
    logic [ADDR_W-1:0] imem_addr;
    logic [7:0]        imem_data;
    logic [3:0]        alu_a;
    logic [3:0]        alu_b;
    logic [3:0]        alu_opcode;
    logic [3:0]        alu_result;
    logic              alu_zero;

    modport master (
        output imem_addr, alu_a, alu_b, alu_opcode,
        input  imem_data, alu_result, alu_zero
    );

    modport slave (
        input  imem_addr, alu_a, alu_b, alu_opcode,
        output imem_data, alu_result, alu_zero
    );
endinterface

// File: rtl/control_unit.sv
// Multi-cycle controller for a tiny 4-register, 4-bit machine: fetches bytes
// from a synchronous-read memory, drives an external ALU and sequences LDI/JZ/HALT.
module control_unit #(
    parameter int ADDR_W = 8
) (
    input  logic          clk,
    input  logic          reset,
    control_unit_if.master bus,
    output logic          instr_done,
    output logic          halted,
    input  logic [1:0]    dbg_sel,
    output logic [3:0]    dbg_data
);

    typedef enum logic [2:0] {
        FETCH,
        DECODE,
        EXEC,
        FETCH2,
        OPERAND,
        HALT
    } state_t;

    localparam logic [3:0] OP_LDI  = 4'b1001;
    localparam logic [3:0] OP_JZ   = 4'b1010;
    localparam logic [3:0] OP_HALT = 4'b1111;

    state_t            state;
    logic [ADDR_W-1:0] pc;
    logic [3:0]        ir_op;
    logic [1:0]        ir_rd;
    logic [3:0]        regs [4];
    logic              z;
    logic [3:0]        alu_a_q;
    logic [3:0]        alu_b_q;
    logic [3:0]        alu_op_q;

    logic [3:0]        dec_op;
    logic [1:0]        dec_rd;
    logic [1:0]        dec_rs;
    logic              dec_alu;
    logic              dec_two_byte;
    logic [ADDR_W-1:0] pc_next;
    logic [ADDR_W-1:0] jump_target;

    // The instruction byte is only valid during DECODE (one cycle after FETCH).
    assign dec_op       = bus.imem_data[7:4];
    assign dec_rd       = bus.imem_data[3:2];
    assign dec_rs       = bus.imem_data[1:0];
    assign dec_alu      = (dec_op >= 4'd1) && (dec_op <= 4'd8);
    assign dec_two_byte = (dec_op == OP_LDI) || (dec_op == OP_JZ);
    assign pc_next      = pc + ADDR_W'(1);
    assign jump_target  = ADDR_W'(bus.imem_data);

    assign bus.imem_addr  = pc;
    assign bus.alu_a      = alu_a_q;
    assign bus.alu_b      = alu_b_q;
    assign bus.alu_opcode = alu_op_q;
    assign dbg_data       = regs[dbg_sel];

    // Single-byte non-ALU instructions retire in DECODE, so this pulse has to
    // look at the incoming byte rather than wait a cycle.
    assign instr_done = (state == EXEC) || (state == OPERAND) ||
                        ((state == DECODE) && !dec_alu && !dec_two_byte);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state    <= FETCH;
            pc       <= '0;
            ir_op    <= '0;
            ir_rd    <= '0;
            z        <= 1'b0;
            halted   <= 1'b0;
            alu_a_q  <= '0;
            alu_b_q  <= '0;
            alu_op_q <= '0;
            regs[0]  <= '0;
            regs[1]  <= '0;
            regs[2]  <= '0;
            regs[3]  <= '0;
        end else begin
            case (state)
                FETCH: begin
                    state <= DECODE;
                end
                DECODE: begin
                    ir_op <= dec_op;
                    ir_rd <= dec_rd;
                    pc    <= pc_next;
                    // Operands are captured here, so rd == rs reads the pre-write value twice.
                    if (dec_alu) begin
                        alu_a_q  <= regs[dec_rd];
                        alu_b_q  <= regs[dec_rs];
                        alu_op_q <= dec_op;
                        state    <= EXEC;
                    end else if (dec_two_byte) begin
                        state <= FETCH2;
                    end else if (dec_op == OP_HALT) begin
                        halted <= 1'b1;
                        state  <= HALT;
                    end else begin
                        state <= FETCH;
                    end
                end
                EXEC: begin
                    regs[ir_rd] <= bus.alu_result;
                    z           <= bus.alu_zero;
                    alu_a_q     <= '0;
                    alu_b_q     <= '0;
                    alu_op_q    <= '0;
                    state       <= FETCH;
                end
                FETCH2: begin
                    state <= OPERAND;
                end
                OPERAND: begin
                    if (ir_op == OP_LDI) begin
                        regs[ir_rd] <= bus.imem_data[3:0];
                    end
                    if ((ir_op == OP_JZ) && z) begin
                        pc <= jump_target;
                    end else begin
                        pc <= pc_next;
                    end
                    state <= FETCH;
                end
                HALT: begin
                    state <= HALT;
                end
                default: begin
                    state <= FETCH;
                end
            endcase
        end
    end

endmodule
